// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter: default geometry and the
// per-port response slot states.
package sram_arb_pkg;
   localparam int ADR_W_DEF  = 7;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      PEND  = 2'd1,
      HOLD  = 2'd2
   } slot_state_t;
endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Requester 0 is the data port, requester 1
// the fetch port; on a tie the requester not granted last wins.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   // Index of the requester granted most recently; resets to 1 so 0 wins first.
   logic last_reg;

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || last_reg)) begin
         gnt[0] = 1'b1;
      end else if (req[1]) begin
         gnt[1] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_reg <= 1'b1;
      end else if (|gnt) begin
         last_reg <= gnt[1];
      end
   end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM macro between a read-only fetch port and a
// read/write data port, with a one-deep response slot per port.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADR_W  = ADR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req_valid,
   output logic                i_req_ready,
   input  logic [ADR_W-1:0]    i_req_adr,
   output logic                i_rsp_valid,
   input  logic                i_rsp_ready,
   output logic [DATA_W-1:0]   i_rsp_data,
   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic                d_req_we,
   input  logic [DATA_W/8-1:0] d_req_wem,
   input  logic [ADR_W-1:0]    d_req_adr,
   input  logic [DATA_W-1:0]   d_req_wdata,
   output logic                d_rsp_valid,
   input  logic                d_rsp_ready,
   output logic [DATA_W-1:0]   d_rsp_data,
   output logic                mem_me,
   output logic                mem_we,
   output logic                mem_oe,
   output logic [ADR_W-1:0]    mem_adr,
   output logic [DATA_W/8-1:0] mem_wem,
   output logic [DATA_W-1:0]   mem_d,
   input  logic [DATA_W-1:0]   mem_q
);
   // Port index 0 = data, 1 = fetch.
   logic [1:0]             req_valid_v;
   logic [1:0]             req_we_v;
   logic [1:0]             rsp_ready_v;
   logic [1:0]             rsp_valid_v;
   logic [1:0]             rsp_accept;
   logic [1:0]             elig;
   logic [1:0]             gnt;
   logic [1:0]             rd_xfer;
   logic [1:0][DATA_W-1:0] rsp_data_v;

   assign req_valid_v = {i_req_valid, d_req_valid};
   assign req_we_v    = {1'b0, d_req_we};
   assign rsp_ready_v = {i_rsp_ready, d_rsp_ready};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gen_slot
         slot_state_t       slot_reg;
         slot_state_t       slot_next;
         logic [DATA_W-1:0] hold_reg;
         logic              capture;

         assign rsp_valid_v[gi] = !rst && (slot_reg != EMPTY);
         assign rsp_accept[gi]  = rsp_valid_v[gi] && rsp_ready_v[gi];
         // A new read may issue only if its response will have somewhere to go.
         assign elig[gi]    = !rst && req_valid_v[gi] &&
                              (req_we_v[gi] || (slot_reg == EMPTY) || rsp_accept[gi]);
         assign rd_xfer[gi] = gnt[gi] && !req_we_v[gi];
         assign rsp_data_v[gi] = (slot_reg == HOLD) ? hold_reg : mem_q;

         always_comb begin
            slot_next = slot_reg;
            capture   = 1'b0;
            case (slot_reg)
               PEND: begin
                  if (rsp_ready_v[gi]) begin
                     slot_next = EMPTY;
                  end else begin
                     slot_next = HOLD;
                     capture   = 1'b1;
                  end
               end
               HOLD: begin
                  if (rsp_ready_v[gi]) slot_next = EMPTY;
               end
               default: slot_next = slot_reg;
            endcase
            if (rd_xfer[gi]) slot_next = PEND;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               slot_reg <= EMPTY;
               hold_reg <= '0;
            end else begin
               slot_reg <= slot_next;
               // Macro Q is only valid in the PEND cycle; park it before it moves.
               if (capture) hold_reg <= mem_q;
            end
         end
      end
   endgenerate

   rr_arb2 u_rr_arb2 (
      .clk (clk),
      .rst (rst),
      .req (elig),
      .gnt (gnt)
   );

   assign d_req_ready = gnt[0];
   assign i_req_ready = gnt[1];
   assign d_rsp_valid = rsp_valid_v[0];
   assign i_rsp_valid = rsp_valid_v[1];
   assign d_rsp_data  = rsp_data_v[0];
   assign i_rsp_data  = rsp_data_v[1];

   assign mem_me  = |gnt;
   assign mem_we  = gnt[0] && d_req_we;
   assign mem_oe  = 1'b1;
   assign mem_adr = gnt[1] ? i_req_adr : (gnt[0] ? d_req_adr : '0);
   assign mem_wem = gnt[0] ? d_req_wem : '0;
   assign mem_d   = d_req_wdata;
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter ADR_W, default 7, meaning word address width of the shared macro.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of the shared macro, DATA_W/8 byte lanes.
REQ-003 SHALL have port clk  input  1  clock; the design uses one clock only.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports i_req_valid in 1, i_req_ready out 1, i_req_adr in ADR_W: the read-only fetch request channel.
REQ-006 SHALL have ports i_rsp_valid out 1, i_rsp_ready in 1, i_rsp_data out DATA_W: the fetch response channel.
REQ-007 SHALL have ports d_req_valid in 1, d_req_ready out 1, d_req_we in 1, d_req_wem in DATA_W/8, d_req_adr in ADR_W, d_req_wdata in DATA_W: the data request channel.
REQ-008 SHALL have ports d_rsp_valid out 1, d_rsp_ready in 1, d_rsp_data out DATA_W: the data read response channel.
REQ-009 SHALL have macro-side ports mem_me, mem_we, mem_oe (out 1 each), mem_adr out ADR_W, mem_wem out DATA_W/8, mem_d out DATA_W, mem_q in DATA_W; the macro has a 1-cycle registered read and holds Q except on read.

Function
REQ-010 A request SHALL transfer on a cycle when valid and ready are both high.
REQ-011 Port eligibility: the port has a request valid, AND it is a write, OR its response slot is EMPTY, OR its slot is non-EMPTY with rsp_valid and rsp_ready both high in that cycle.
REQ-012 At most one port SHALL be granted per cycle; ready SHALL be high only for the granted port.
REQ-013 Arbitration: if only one port is eligible, that port is granted; if both are eligible, the port not granted last is granted (round-robin); the last-granted pointer updates only on a transfer.
REQ-014 On grant, the block SHALL drive the following in the same cycle, combinationally: mem_me=1, mem_adr=the granted adr, mem_we=d_req_we (0 for the fetch port), mem_wem=d_req_wem, mem_d=d_req_wdata.
REQ-015 With no grant: mem_me=0, mem_we=0, mem_wem=0; mem_oe SHALL be constant 1.
REQ-016 Writes are posted and SHALL produce no response or slot; a write with wem=0 is still issued.
REQ-017 Per-port response slot FSM: EMPTY -> PEND on read transfer; PEND -> EMPTY if rsp_ready, else -> HOLD; HOLD -> EMPTY on rsp_ready; any state -> PEND on a read transfer in the same cycle the previous response is accepted.
REQ-018 rsp_valid = slot != EMPTY; rsp_data = mem_q in PEND, hold register in HOLD.
REQ-019 The hold register SHALL capture mem_q on the PEND -> HOLD transition.
REQ-020 Read latency SHALL be 1 cycle from transfer to rsp_valid; back-to-back reads on one port SHALL sustain 1 per cycle when rsp_ready=1 and the other port is idle.
REQ-021 A simultaneous fetch read and data write SHALL be serialized by round-robin; read-after-write to the same address, issued in later cycles, SHALL return the new data.
REQ-022 Each port SHALL have at most one outstanding read.

Reset
REQ-023 While rst=1: all slots EMPTY, pointer set so the data port wins the first tie, all ready/rsp_valid=0, mem_me=0, mem_we=0, mem_wem=0; hold registers are 0.
REQ-024 Reset mid-operation SHALL discard pending/held responses; no response for a pre-reset request SHALL appear after reset.

Structure
REQ-025 A shared package sram_arb_pkg SHALL hold the ADR_W/DATA_W defaults and the slot_state_t enum (EMPTY, PEND, HOLD).
REQ-026 One sub-module rr_arb2 (2-way round-robin, request/grant, pointer register) SHALL be used; slot FSMs SHALL be inline.

Verification
REQ-027 The bench SHALL cover: data write adr 5, wem 4'b0011, wdata 0xAABBCCDD over 0; then fetch read adr 5 -> i_rsp_data 0x0000CCDD one cycle after transfer.
REQ-028 The bench SHALL cover: both ports valid every cycle from reset, all reads -> grants alternate D,I,D,I; each rsp_valid exactly 1 cycle after its transfer.
REQ-029 The bench SHALL cover: fetch read adr 3 (mem=0x12345678), i_rsp_ready=0 for 3 cycles while data reads adr 4 -> i_rsp_data stays 0x12345678, i_req_ready=0 until accepted.
REQ-030 The bench SHALL cover: fetch streams reads adr 0..7 with rsp_ready=1, data idle -> 8 responses in 8 consecutive cycles, in order.
REQ-031 The bench SHALL cover: rst asserted for 1 cycle while data slot is HOLD -> d_rsp_valid=0 the next cycle and thereafter until a new read.
REQ-032 The bench SHALL cover: data write with wem=0 to adr 9 -> mem_me=1, mem_we=1, and stored data unchanged on later read.
